mem_port_ctrl: RTL and testbench
================================

# mem_port_ctrl

CPU-side initiator for the dual-port main memory: turns single-cycle datapath requests (word read, word write, instruction-byte fetch) into properly timed port A / port B memory strobes and captures the returned word into MDR and the returned byte into MBR. It sits between the Mic-1 datapath/control store and the main memory. Both ports have independent state machines, so a word access and a fetch can be in flight at once.

## Interface

- MEM_WORDS, 512, number of 32-bit words in main memory; used for address range checking
- clk  in  1  system clock; memory samples on negedge, this block on posedge
- rst_n  in  1  asynchronous active-low reset
- req_rd  in  1  word read request from datapath, word address on mar
- req_wr  in  1  word write request, word address on mar, data on mdr_in
- req_fetch  in  1  byte fetch request, byte address on pc
- mar  in  32  word address for port A
- mdr_in  in  32  write data
- pc  in  32  byte address for port B
- a_ready  out  1  port A idle, request accepted this cycle if asserted
- b_ready  out  1  port B idle, fetch accepted this cycle if asserted
- mdr  out  32  last word read
- mdr_valid  out  1  one-cycle pulse: mdr just updated
- mbr  out  8  last fetched byte
- mbru  out  32  mbr zero-extended
- mbrs  out  32  mbr sign-extended
- mbr_valid  out  1  one-cycle pulse: mbr just updated
- addr_err  out  1  one-cycle pulse: out-of-range request rejected
- proto_err  out  1  one-cycle pulse: req_rd and req_wr together, rejected
- wen_A, ren_A  out  1  memory port A strobes
- addr_A, wdata_A  out  32  memory port A word address / write data
- rdata_A  in  32  memory port A read data
- ren_B  out  1  memory port B strobe
- addr_B  out  32  memory port B byte address
- rdata_B  in  8  memory port B byte

## Operation

- Port A FSM: A_IDLE, A_RD, A_WR. a_ready = (state == A_IDLE).
- A_IDLE, req_rd only, mar < MEM_WORDS: register addr_A <= mar, ren_A <= 1, go A_RD.
- A_IDLE, req_wr only, mar < MEM_WORDS: register addr_A <= mar, wdata_A <= mdr_in, wen_A <= 1, go A_WR.
- A_RD: capture mdr <= rdata_A, drop ren_A, pulse mdr_valid next cycle, go A_IDLE.
- A_WR: drop wen_A, go A_IDLE; mdr unchanged.
- req_rd and req_wr together in A_IDLE: no access, proto_err pulse, stay A_IDLE (proto_err takes priority over addr_err).
- mar >= MEM_WORDS on an accepted rd/wr: no strobe, addr_err pulse, stay A_IDLE.
- Requests when not ready are ignored (no queueing); datapath must hold or retry.
- Port B FSM: B_IDLE, B_FETCH. b_ready = (state == B_IDLE).
- B_IDLE, req_fetch, (pc >> 2) < MEM_WORDS: addr_B <= pc, ren_B <= 1, go B_FETCH. Out of range: addr_err pulse, no strobe.
- B_FETCH: capture mbr <= rdata_B, drop ren_B, pulse mbr_valid next cycle, go B_IDLE.
- addr_B holds its value until the next accepted fetch; it must not change while the byte is being captured, because the memory selects the byte lane combinationally from addr_B[1:0].
- addr_err from both ports in the same cycle: single-cycle pulse (OR).
- mbru = {24'b0, mbr}; mbrs = {{24{mbr[7]}}, mbr}.

## Timing

- Reset (async assert, sync-safe deassert): both FSMs idle; every output 0 except a_ready = b_ready = 1.
- Read: request accepted in cycle T; ren_A/addr_A valid during T+1; memory reads at the negedge inside T+1; mdr updated at the posedge ending T+1; mdr_valid high in T+2. Latency 2; next port A request is accepted in T+2.
- Write: accepted in T; wen_A/addr_A/wdata_A high during T+1 only; memory written at that negedge; a_ready back in T+2.
- Fetch: same timing as a read on port B; mbr/mbr_valid in T+2.
- Port A and port B requests in the same cycle both proceed; a read and a write to the same word with a fetch in flight give no ordering guarantee.
- Reset mid-operation: strobes drop immediately; mdr/mbr clear to 0; no valid pulse is produced.

## Test plan

- After reset: mem[5]=32'hDEADBEEF; req_rd, mar=5 in cycle T -> ren_A high only in T+1, mdr=32'hDEADBEEF, mdr_valid pulse in T+2.
- req_wr, mar=7, mdr_in=32'h12345678 in T, then req_rd mar=7 in T+2 -> wen_A high only in T+1; mdr=32'h12345678 in T+4.
- Fetch pc=0..7 back-to-back with mem[0]=32'h44332211, mem[1]=32'h88776655 -> mbr 11,22,33,44,55,66,77,88 every 2 cycles; for byte 88: mbrs=32'hFFFFFF88, mbru=32'h00000088.
- req_rd and req_wr together -> proto_err 1 cycle, no strobe, a_ready stays 1. mar=512 -> addr_err, no strobe. pc=2048 -> addr_err.
- Read on port A and fetch on port B in the same cycle -> both valid pulses in T+2 with correct data. Request while a_ready=0 -> ignored.
- Assert rst_n low in T+1 of a read -> ren_A drops at once, mdr=0, no mdr_valid.

Source files
------------

// File: rtl/mem_port_if.sv
// Signal bundle between the datapath/memory environment and mem_port_ctrl.
// Holds the datapath request/response side and both main-memory ports.
interface mem_port_if;
  // A request is taken at the rising edge only when req_* is high and the
  // matching a_ready/b_ready is high in that cycle; otherwise it is dropped,
  // so the requester holds or retries. Responses are single-cycle *_valid pulses.
  logic        req_rd;
  logic        req_wr;
  logic        req_fetch;
  logic [31:0] mar;
  logic [31:0] mdr_in;
  logic [31:0] pc;
  logic        a_ready;
  logic        b_ready;
  logic [31:0] mdr;
  logic        mdr_valid;
  logic [7:0]  mbr;
  logic [31:0] mbru;
  logic [31:0] mbrs;
  logic        mbr_valid;
  logic        addr_err;
  logic        proto_err;
  logic        wen_A;
  logic        ren_A;
  logic [31:0] addr_A;
  logic [31:0] wdata_A;
  logic [31:0] rdata_A;
  logic        ren_B;
  logic [31:0] addr_B;
  logic [7:0]  rdata_B;

  modport master (
    output req_rd, req_wr, req_fetch, mar, mdr_in, pc, rdata_A, rdata_B,
    input  a_ready, b_ready, mdr, mdr_valid, mbr, mbru, mbrs, mbr_valid,
           addr_err, proto_err, wen_A, ren_A, addr_A, wdata_A, ren_B, addr_B
  );

  modport slave (
    input  req_rd, req_wr, req_fetch, mar, mdr_in, pc, rdata_A, rdata_B,
    output a_ready, b_ready, mdr, mdr_valid, mbr, mbru, mbrs, mbr_valid,
           addr_err, proto_err, wen_A, ren_A, addr_A, wdata_A, ren_B, addr_B
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Mic-1 memory initiator: port A word read/write FSM and port B byte-fetch FSM,
// running independently, with registered strobes and MDR/MBR capture.
module mem_port_ctrl #(
  parameter int MEM_WORDS = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_port_if.slave  bus,
  output logic [1:0] a_state_dbg,
  output logic       b_state_dbg
);

  typedef enum logic [1:0] {A_IDLE = 2'd0, A_RD = 2'd1, A_WR = 2'd2} a_state_t;
  typedef enum logic       {B_IDLE = 1'b0, B_FETCH = 1'b1} b_state_t;

  a_state_t    a_state, a_state_n;
  b_state_t    b_state, b_state_n;

  logic        ren_a_q, ren_a_n;
  logic        wen_a_q, wen_a_n;
  logic [31:0] addr_a_q, addr_a_n;
  logic [31:0] wdata_a_q, wdata_a_n;
  logic [31:0] mdr_q, mdr_n;
  logic        mdr_valid_q, mdr_valid_n;
  logic        proto_err_q, proto_err_n;
  logic        addr_err_a, addr_err_b;
  logic        addr_err_q;
  logic        ren_b_q, ren_b_n;
  logic [31:0] addr_b_q, addr_b_n;
  logic [7:0]  mbr_q, mbr_n;
  logic        mbr_valid_q, mbr_valid_n;

  logic        mar_ok, pc_ok;

  assign mar_ok = bus.mar < 32'(MEM_WORDS);
  assign pc_ok  = (bus.pc >> 2) < 32'(MEM_WORDS);

  always_comb begin
    a_state_n   = a_state;
    ren_a_n     = 1'b0;
    wen_a_n     = 1'b0;
    addr_a_n    = addr_a_q;
    wdata_a_n   = wdata_a_q;
    mdr_n       = mdr_q;
    mdr_valid_n = 1'b0;
    proto_err_n = 1'b0;
    addr_err_a  = 1'b0;
    case (a_state)
      A_IDLE: begin
        // A simultaneous read+write is a protocol error regardless of address.
        if (bus.req_rd && bus.req_wr) begin
          proto_err_n = 1'b1;
        end else if (bus.req_rd || bus.req_wr) begin
          if (!mar_ok) begin
            addr_err_a = 1'b1;
          end else begin
            addr_a_n = bus.mar;
            if (bus.req_wr) begin
              wdata_a_n = bus.mdr_in;
              wen_a_n   = 1'b1;
              a_state_n = A_WR;
            end else begin
              ren_a_n   = 1'b1;
              a_state_n = A_RD;
            end
          end
        end
      end
      A_RD: begin
        mdr_n       = bus.rdata_A;
        mdr_valid_n = 1'b1;
        a_state_n   = A_IDLE;
      end
      A_WR:    a_state_n = A_IDLE;
      default: a_state_n = A_IDLE;
    endcase
  end

  always_comb begin
    b_state_n   = b_state;
    ren_b_n     = 1'b0;
    addr_b_n    = addr_b_q;
    mbr_n       = mbr_q;
    mbr_valid_n = 1'b0;
    addr_err_b  = 1'b0;
    case (b_state)
      B_IDLE: begin
        if (bus.req_fetch) begin
          if (!pc_ok) begin
            addr_err_b = 1'b1;
          end else begin
            addr_b_n  = bus.pc;
            ren_b_n   = 1'b1;
            b_state_n = B_FETCH;
          end
        end
      end
      B_FETCH: begin
        // addr_B is left untouched here: memory picks the byte lane from it.
        mbr_n       = bus.rdata_B;
        mbr_valid_n = 1'b1;
        b_state_n   = B_IDLE;
      end
      default: b_state_n = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state     <= A_IDLE;
      b_state     <= B_IDLE;
      ren_a_q     <= 1'b0;
      wen_a_q     <= 1'b0;
      addr_a_q    <= '0;
      wdata_a_q   <= '0;
      mdr_q       <= '0;
      mdr_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      ren_b_q     <= 1'b0;
      addr_b_q    <= '0;
      mbr_q       <= '0;
      mbr_valid_q <= 1'b0;
    end else begin
      a_state     <= a_state_n;
      b_state     <= b_state_n;
      ren_a_q     <= ren_a_n;
      wen_a_q     <= wen_a_n;
      addr_a_q    <= addr_a_n;
      wdata_a_q   <= wdata_a_n;
      mdr_q       <= mdr_n;
      mdr_valid_q <= mdr_valid_n;
      proto_err_q <= proto_err_n;
      addr_err_q  <= addr_err_a | addr_err_b;
      ren_b_q     <= ren_b_n;
      addr_b_q    <= addr_b_n;
      mbr_q       <= mbr_n;
      mbr_valid_q <= mbr_valid_n;
    end
  end

  assign bus.a_ready   = (a_state == A_IDLE);
  assign bus.b_ready   = (b_state == B_IDLE);
  assign bus.ren_A     = ren_a_q;
  assign bus.wen_A     = wen_a_q;
  assign bus.addr_A    = addr_a_q;
  assign bus.wdata_A   = wdata_a_q;
  assign bus.mdr       = mdr_q;
  assign bus.mdr_valid = mdr_valid_q;
  assign bus.proto_err = proto_err_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.ren_B     = ren_b_q;
  assign bus.addr_B    = addr_b_q;
  assign bus.mbr       = mbr_q;
  assign bus.mbru      = {24'b0, mbr_q};
  assign bus.mbrs      = {{24{mbr_q[7]}}, mbr_q};
  assign bus.mbr_valid = mbr_valid_q;
  assign a_state_dbg   = a_state;
  assign b_state_dbg   = b_state;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: behavioural memory on the strobes, reference word
// array for expected data, directed scenarios plus randomized traffic.
module tb_mem_port_ctrl;
  localparam int MEM_WORDS = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a_state_dbg;
  logic       b_state_dbg;

  always #5 clk = ~clk;

  mem_port_if bus ();

  mem_port_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .a_state_dbg (a_state_dbg),
    .b_state_dbg (b_state_dbg)
  );

  // Main memory: samples strobes on the falling edge; backdoor port for preload.
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        bd_we = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(negedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.wen_A) mem[bus.addr_A[8:0]] <= bus.wdata_A;
    if (bus.ren_A) bus.rdata_A <= mem[bus.addr_A[8:0]];
    if (bus.ren_B) bus.rdata_B <= 8'(mem[bus.addr_B[10:2]] >> {bus.addr_B[1:0], 3'b000});
  end

  // Reference model
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic [31:0] exp_q[$];
  logic [31:0] exp_mdr = '0;
  logic [7:0]  exp_mbr = '0;

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input logic [31:0] a);
    logic ok;
    ok = (a < MEM_WORDS);
    bus.req_rd = 1'b1;
    bus.mar    = a;
    if (ok) exp_q.push_back(ref_mem[a[8:0]]);
    tick();
    bus.req_rd = 1'b0;
    total++; if (bus.ren_A !== ok) begin bad++; $display("FAIL rd_ren a=%0h got=%b exp=%b", a, bus.ren_A, ok); end
    total++; if (bus.addr_err !== !ok) begin bad++; $display("FAIL rd_addr_err a=%0h got=%b exp=%b", a, bus.addr_err, !ok); end
    total++; if (bus.a_ready !== !ok) begin bad++; $display("FAIL rd_busy a=%0h got=%b exp=%b", a, bus.a_ready, !ok); end
    total++; if (bus.wen_A !== 1'b0) begin bad++; $display("FAIL rd_no_wen a=%0h got=%b exp=0", a, bus.wen_A); end
    if (ok) begin
      total++; if (bus.addr_A !== a) begin bad++; $display("FAIL rd_addr_A got=%0h exp=%0h", bus.addr_A, a); end
    end
    tick();
    total++; if (bus.ren_A !== 1'b0) begin bad++; $display("FAIL rd_ren_drop a=%0h got=%b exp=0", a, bus.ren_A); end
    total++; if (bus.mdr_valid !== ok) begin bad++; $display("FAIL rd_valid a=%0h got=%b exp=%b", a, bus.mdr_valid, ok); end
    if (ok) exp_mdr = exp_q.pop_front();
    total++; if (bus.mdr !== exp_mdr) begin bad++; $display("FAIL rd_mdr a=%0h got=%h exp=%h", a, bus.mdr, exp_mdr); end
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_back got=%b exp=1", bus.a_ready); end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = (a < MEM_WORDS);
    bus.req_wr = 1'b1;
    bus.mar    = a;
    bus.mdr_in = d;
    tick();
    bus.req_wr = 1'b0;
    total++; if (bus.wen_A !== ok) begin bad++; $display("FAIL wr_wen a=%0h got=%b exp=%b", a, bus.wen_A, ok); end
    total++; if (bus.ren_A !== 1'b0) begin bad++; $display("FAIL wr_no_ren got=%b exp=0", bus.ren_A); end
    total++; if (bus.addr_err !== !ok) begin bad++; $display("FAIL wr_addr_err a=%0h got=%b exp=%b", a, bus.addr_err, !ok); end
    if (ok) begin
      total++; if (bus.addr_A !== a) begin bad++; $display("FAIL wr_addr_A got=%0h exp=%0h", bus.addr_A, a); end
      total++; if (bus.wdata_A !== d) begin bad++; $display("FAIL wr_wdata got=%h exp=%h", bus.wdata_A, d); end
      ref_mem[a[8:0]] = d;
    end
    tick();
    total++; if (bus.wen_A !== 1'b0) begin bad++; $display("FAIL wr_wen_drop got=%b exp=0", bus.wen_A); end
    total++; if (bus.mdr_valid !== 1'b0) begin bad++; $display("FAIL wr_no_valid got=%b exp=0", bus.mdr_valid); end
    total++; if (bus.mdr !== exp_mdr) begin bad++; $display("FAIL wr_mdr_kept got=%h exp=%h", bus.mdr, exp_mdr); end
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_back got=%b exp=1", bus.a_ready); end
  endtask

  task automatic fetch_byte(input logic [31:0] p);
    logic        ok;
    logic [31:0] w;
    logic [31:0] exp_s;
    ok = ((p >> 2) < MEM_WORDS);
    bus.req_fetch = 1'b1;
    bus.pc        = p;
    tick();
    bus.req_fetch = 1'b0;
    total++; if (bus.ren_B !== ok) begin bad++; $display("FAIL f_ren p=%0h got=%b exp=%b", p, bus.ren_B, ok); end
    total++; if (bus.addr_err !== !ok) begin bad++; $display("FAIL f_addr_err p=%0h got=%b exp=%b", p, bus.addr_err, !ok); end
    total++; if (bus.b_ready !== !ok) begin bad++; $display("FAIL f_busy p=%0h got=%b exp=%b", p, bus.b_ready, !ok); end
    if (ok) begin
      total++; if (bus.addr_B !== p) begin bad++; $display("FAIL f_addr_B got=%0h exp=%0h", bus.addr_B, p); end
      w = ref_mem[p[10:2]];
      exp_mbr = 8'((w / (32'd1 << (8 * p[1:0]))) % 256);
    end
    tick();
    total++; if (bus.ren_B !== 1'b0) begin bad++; $display("FAIL f_ren_drop got=%b exp=0", bus.ren_B); end
    total++; if (bus.mbr_valid !== ok) begin bad++; $display("FAIL f_valid p=%0h got=%b exp=%b", p, bus.mbr_valid, ok); end
    total++; if (bus.mbr !== exp_mbr) begin bad++; $display("FAIL f_mbr p=%0h got=%h exp=%h", p, bus.mbr, exp_mbr); end
    total++; if (bus.mbru !== 32'(exp_mbr)) begin bad++; $display("FAIL f_mbru got=%h exp=%h", bus.mbru, 32'(exp_mbr)); end
    exp_s = (exp_mbr >= 8'd128) ? 32'(exp_mbr) + 32'hFFFFFF00 : 32'(exp_mbr);
    total++; if (bus.mbrs !== exp_s) begin bad++; $display("FAIL f_mbrs got=%h exp=%h", bus.mbrs, exp_s); end
    if (ok) begin
      total++; if (bus.addr_B !== p) begin bad++; $display("FAIL f_addr_B_hold got=%0h exp=%0h", bus.addr_B, p); end
    end
  endtask

  task automatic par_rd_fetch(input logic [31:0] a, input logic [31:0] p);
    logic [31:0] w;
    bus.req_rd    = 1'b1;
    bus.mar       = a;
    bus.req_fetch = 1'b1;
    bus.pc        = p;
    exp_q.push_back(ref_mem[a[8:0]]);
    w = ref_mem[p[10:2]];
    tick();
    bus.req_rd    = 1'b0;
    bus.req_fetch = 1'b0;
    total++; if ({bus.ren_A, bus.ren_B} !== 2'b11) begin bad++; $display("FAIL par_strobes got=%b exp=11", {bus.ren_A, bus.ren_B}); end
    tick();
    total++; if ({bus.mdr_valid, bus.mbr_valid} !== 2'b11) begin bad++; $display("FAIL par_valids got=%b exp=11", {bus.mdr_valid, bus.mbr_valid}); end
    exp_mdr = exp_q.pop_front();
    exp_mbr = 8'((w / (32'd1 << (8 * p[1:0]))) % 256);
    total++; if (bus.mdr !== exp_mdr) begin bad++; $display("FAIL par_mdr got=%h exp=%h", bus.mdr, exp_mdr); end
    total++; if (bus.mbr !== exp_mbr) begin bad++; $display("FAIL par_mbr got=%h exp=%h", bus.mbr, exp_mbr); end
  endtask

  task automatic test_reset();
    bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.req_fetch = 1'b0;
    bus.mar = '0; bus.mdr_in = '0; bus.pc = '0;
    rst_n = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      case (i)
        0:       ref_mem[i] = 32'h44332211;
        1:       ref_mem[i] = 32'h88776655;
        5:       ref_mem[i] = 32'hDEADBEEF;
        default: ref_mem[i] = $urandom;
      endcase
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = 9'(i); bd_data = ref_mem[i];
    end
    tick();
    bd_we = 1'b0;
    total++; if ({bus.a_ready, bus.b_ready, bus.ren_A, bus.wen_A, bus.ren_B} !== 5'b11000) begin
      bad++; $display("FAIL rst_ctrl got=%b exp=11000", {bus.a_ready, bus.b_ready, bus.ren_A, bus.wen_A, bus.ren_B}); end
    total++; if ({bus.mdr_valid, bus.mbr_valid, bus.addr_err, bus.proto_err} !== 4'b0000) begin
      bad++; $display("FAIL rst_pulses got=%b exp=0000", {bus.mdr_valid, bus.mbr_valid, bus.addr_err, bus.proto_err}); end
    total++; if (bus.mdr !== 32'h0) begin bad++; $display("FAIL rst_mdr got=%h exp=0", bus.mdr); end
    total++; if ({bus.mbr, bus.mbru, bus.mbrs} !== 72'h0) begin bad++; $display("FAIL rst_mbr got=%h exp=0", {bus.mbr, bus.mbru, bus.mbrs}); end
    total++; if ({bus.addr_A, bus.wdata_A, bus.addr_B} !== 96'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", {bus.addr_A, bus.wdata_A, bus.addr_B}); end
    total++; if ({a_state_dbg, b_state_dbg} !== 3'b000) begin bad++; $display("FAIL rst_state got=%b exp=000", {a_state_dbg, b_state_dbg}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    read_word(32'd5);
    total++; if (bus.mdr !== 32'hDEADBEEF) begin bad++; $display("FAIL read5_const got=%h exp=deadbeef", bus.mdr); end
    tick();
    total++; if (bus.mdr_valid !== 1'b0) begin bad++; $display("FAIL read_valid_once got=%b exp=0", bus.mdr_valid); end
  endtask

  task automatic test_write_read();
    write_word(32'd7, 32'h12345678);
    read_word(32'd7);
    total++; if (bus.mdr !== 32'h12345678) begin bad++; $display("FAIL wr_rd7_const got=%h exp=12345678", bus.mdr); end
  endtask

  task automatic test_back_to_back_fetch();
    for (int p = 0; p < 8; p++) fetch_byte(32'(p));
    total++; if (bus.mbrs !== 32'hFFFFFF88 || bus.mbru !== 32'h00000088) begin
      bad++; $display("FAIL fetch88_ext got=%h/%h exp=ffffff88/00000088", bus.mbrs, bus.mbru); end
  endtask

  task automatic test_errors();
    bus.req_rd = 1'b1; bus.req_wr = 1'b1; bus.mar = 32'd3;
    tick();
    bus.req_rd = 1'b0; bus.req_wr = 1'b0;
    total++; if ({bus.proto_err, bus.addr_err, bus.ren_A, bus.wen_A, bus.a_ready} !== 5'b10001) begin
      bad++; $display("FAIL proto got=%b exp=10001", {bus.proto_err, bus.addr_err, bus.ren_A, bus.wen_A, bus.a_ready}); end
    tick();
    total++; if (bus.proto_err !== 1'b0) begin bad++; $display("FAIL proto_pulse got=%b exp=0", bus.proto_err); end
    bus.req_rd = 1'b1; bus.req_wr = 1'b1; bus.mar = 32'd900;
    tick();
    bus.req_rd = 1'b0; bus.req_wr = 1'b0;
    total++; if ({bus.proto_err, bus.addr_err} !== 2'b10) begin bad++; $display("FAIL proto_prio got=%b exp=10", {bus.proto_err, bus.addr_err}); end
    tick();
    read_word(32'd512);
    fetch_byte(32'd2048);
    bus.req_rd = 1'b1; bus.mar = 32'd600; bus.req_fetch = 1'b1; bus.pc = 32'd4096;
    tick();
    bus.req_rd = 1'b0; bus.req_fetch = 1'b0;
    total++; if ({bus.addr_err, bus.ren_A, bus.ren_B} !== 3'b100) begin bad++; $display("FAIL both_oor got=%b exp=100", {bus.addr_err, bus.ren_A, bus.ren_B}); end
    tick();
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL both_oor_pulse got=%b exp=0", bus.addr_err); end
  endtask

  task automatic test_parallel();
    par_rd_fetch(32'd5, 32'd3);
    par_rd_fetch(32'd1, 32'd6);
  endtask

  task automatic test_ignore_busy();
    bus.req_rd = 1'b1; bus.mar = 32'd9;
    tick();
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b1; bus.mar = 32'd9; bus.mdr_in = 32'hCAFEF00D;
    total++; if (bus.a_ready !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b exp=0", bus.a_ready); end
    tick();
    bus.req_wr = 1'b0;
    exp_mdr = ref_mem[9];
    total++; if (bus.wen_A !== 1'b0) begin bad++; $display("FAIL ign_wen got=%b exp=0", bus.wen_A); end
    total++; if (bus.mdr !== exp_mdr) begin bad++; $display("FAIL ign_mdr got=%h exp=%h", bus.mdr, exp_mdr); end
    tick();
    total++; if (bus.wen_A !== 1'b0) begin bad++; $display("FAIL ign_wen2 got=%b exp=0", bus.wen_A); end
    read_word(32'd9);
  endtask

  task automatic test_reset_mid();
    bus.req_rd = 1'b1; bus.mar = 32'd5;
    tick();
    bus.req_rd = 1'b0;
    total++; if (bus.ren_A !== 1'b1) begin bad++; $display("FAIL rmid_ren got=%b exp=1", bus.ren_A); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_mdr = '0;
    exp_mbr = '0;
    total++; if ({bus.ren_A, bus.a_ready} !== 2'b01) begin bad++; $display("FAIL rmid_drop got=%b exp=01", {bus.ren_A, bus.a_ready}); end
    total++; if ({bus.mdr, bus.mbr} !== 40'h0) begin bad++; $display("FAIL rmid_clear got=%h exp=0", {bus.mdr, bus.mbr}); end
    tick();
    total++; if (bus.mdr_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.mdr_valid); end
    rst_n = 1'b1;
    tick();
    total++; if ({bus.mdr_valid, bus.mdr} !== 33'h0) begin bad++; $display("FAIL rmid_after got=%h exp=0", {bus.mdr_valid, bus.mdr}); end
  endtask

  task automatic test_random();
    int          op;
    logic [31:0] a;
    logic [31:0] p;
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(MEM_WORDS, 4 * MEM_WORDS))
                                       : 32'($urandom_range(0, MEM_WORDS - 1));
      p  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4 * MEM_WORDS, 16 * MEM_WORDS))
                                       : 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      case (op)
        0: read_word(a);
        1: write_word(a, $urandom);
        2: fetch_byte(p);
        default: begin
          if (a < MEM_WORDS && (p >> 2) < MEM_WORDS) par_rd_fetch(a, p);
          else read_word(a);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back_fetch();
    test_errors();
    test_parallel();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
